// File: rtl/iir_out_fifo.sv
// iir_out_fifo: first-word-fall-through output FIFO behind the IIR filter.
// No backpressure to the filter; samples arriving while full are dropped.
//
// Parameters:
//   NB    - sample width in bits (filter output width)
//   DEPTH - number of storage entries, power of two, >= 2
//   CW    - count width, clog2(DEPTH+1)
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   vIn/dIn  - sample from the filter (vOut/dOut of the filter)
//   ready    - consumer takes the head sample this cycle
//   vOut     - head sample valid (FIFO not empty)
//   dOut     - head sample, valid only while vOut = 1
//   count    - occupancy, 0..DEPTH
//   full     - count == DEPTH
//   ovf      - sticky, set when a sample is dropped
//   drop_cnt - saturating count of dropped samples
// Build option:
//   IIR_OUT_FIFO_DROP_CNT_EN - enables drop_cnt; when undefined it reads 0.

module iir_out_fifo #(
    parameter int NB    = 12,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vIn,
    input  logic [NB-1:0] dIn,
    input  logic          ready,
    output logic          vOut,
    output logic [NB-1:0] dOut,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovf,
    output logic [15:0]   drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NB-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic push;
    logic pop;
    logic drop;

    assign vOut = (count != '0);
    assign full = (count == CW'(DEPTH));
    assign dOut = mem[rd_ptr];

    assign pop  = vOut & ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = vIn & (~full | pop);
    assign drop = vIn & full & ~pop;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= dIn;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef IIR_OUT_FIFO_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_iir_out_fifo.sv
// tb_iir_out_fifo: self-checking bench for iir_out_fifo.
// Table vectors, directed corner sequences and a random run vs a queue model.

module tb_iir_out_fifo;

    localparam int NB    = 12;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vIn = 1'b0;
    logic [NB-1:0] dIn = '0;
    logic          ready = 1'b0;
    logic          vOut;
    logic [NB-1:0] dOut;
    logic [CW-1:0] count;
    logic          full;
    logic          ovf;
    logic [15:0]   drop_cnt;

    iir_out_fifo #(.NB(NB), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .vIn      (vIn),
        .dIn      (dIn),
        .ready    (ready),
        .vOut     (vOut),
        .dOut     (dOut),
        .count    (count),
        .full     (full),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue plus sticky flag and drop tally.
    int m_q[$];
    bit m_ovf   = 1'b0;
    int m_drops = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int d, input bit rd);
        bit was_nonempty;
        if (r) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
            return;
        end
        was_nonempty = (m_q.size() > 0);
        if (was_nonempty && rd) void'(m_q.pop_front());
        if (v) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
`ifdef IIR_OUT_FIFO_DROP_CNT_EN
                if (m_drops < 65535) m_drops++;
`endif
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".vOut"},  int'(vOut),  int'(m_q.size() > 0));
        chk({tag, ".count"}, int'(count), m_q.size());
        chk({tag, ".full"},  int'(full),  int'(m_q.size() == DEPTH));
        chk({tag, ".ovf"},   int'(ovf),   int'(m_ovf));
        chk({tag, ".drop"},  int'(drop_cnt), m_drops);
        if (m_q.size() > 0) chk({tag, ".dOut"}, int'(dOut), m_q[0]);
    endtask

    // Drive one cycle, advance model, check after the edge.
    task automatic apply(input bit r, input bit v, input int d, input bit rd,
                         input string tag);
        rst   = r;
        vIn   = v;
        dIn   = NB'(d);
        ready = rd;
        model_step(r, v, d, rd);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit r;
        bit v;
        int d;
        bit rd;
        bit e_vout;
        int e_dout;
        int e_count;
        bit e_full;
        bit e_ovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Fill/drain 1,2,3, then single-sample latency with 12'h7FF.
        vecs[0] = '{1, 1, 5,     1, 0, 0,     0, 0, 0};
        vecs[1] = '{0, 1, 1,     0, 1, 1,     1, 0, 0};
        vecs[2] = '{0, 1, 2,     0, 1, 1,     2, 0, 0};
        vecs[3] = '{0, 1, 3,     0, 1, 1,     3, 0, 0};
        vecs[4] = '{0, 0, 0,     1, 1, 2,     2, 0, 0};
        vecs[5] = '{0, 0, 0,     1, 1, 3,     1, 0, 0};
        vecs[6] = '{0, 0, 0,     1, 0, 0,     0, 0, 0};
        vecs[7] = '{0, 1, 'h7FF, 1, 1, 'h7FF, 1, 0, 0};
        vecs[8] = '{0, 0, 0,     1, 0, 0,     0, 0, 0};

        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].rd,
                  $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.vOut_c", i),  int'(vOut),  int'(vecs[i].e_vout));
            chk($sformatf("vec%0d.count_c", i), int'(count), vecs[i].e_count);
            chk($sformatf("vec%0d.full_c", i),  int'(full),  int'(vecs[i].e_full));
            chk($sformatf("vec%0d.ovf_c", i),   int'(ovf),   int'(vecs[i].e_ovf));
            if (vecs[i].e_vout)
                chk($sformatf("vec%0d.dOut_c", i), int'(dOut), vecs[i].e_dout);
        end

        // Overflow: 10 pushes into DEPTH=8 with ready low.
        apply(1, 0, 0, 0, "ovf.rst");
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, i, 0, $sformatf("ovf.push%0d", i));
            if (i == 7) begin
                chk("ovf.full_at8", int'(full), 1);
                chk("ovf.ovf_at8",  int'(ovf),  0);
            end
            if (i == 8) chk("ovf.ovf_at9", int'(ovf), 1);
        end
`ifdef IIR_OUT_FIFO_DROP_CNT_EN
        chk("ovf.drop_cnt", int'(drop_cnt), 2);
`else
        chk("ovf.drop_cnt", int'(drop_cnt), 0);
`endif
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf.drain%0d", i), int'(dOut), i);
            apply(0, 0, 0, 1, $sformatf("ovf.pop%0d", i));
        end
        chk("ovf.empty", int'(vOut), 0);

        // Full push+pop in the same cycle.
        apply(1, 0, 0, 0, "fpp.rst");
        for (int i = 0; i < 8; i++) apply(0, 1, i, 0, "fpp.fill");
        apply(0, 1, 8, 1, "fpp.both");
        chk("fpp.count", int'(count), 8);
        chk("fpp.ovf",   int'(ovf),   0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("fpp.drain%0d", i), int'(dOut), i);
            apply(0, 0, 0, 1, "fpp.pop");
        end

        // Wrap: ready held high, random vIn duty.
        apply(1, 0, 0, 0, "wrap.rst");
        begin
            int out_seq[$];
            int in_seq[$];
            for (int i = 0; i < 20; i++) begin
                bit v;
                int d;
                v = ($urandom_range(0, 2) != 0);
                d = int'($urandom_range(0, 4095));
                if (vOut) out_seq.push_back(int'(dOut));
                if (v) in_seq.push_back(d);
                apply(0, v, d, 1, "wrap");
                chk("wrap.count_le1", int'(count <= 1), 1);
            end
            if (vOut) out_seq.push_back(int'(dOut));
            apply(0, 0, 0, 1, "wrap.last");
            chk("wrap.nout", out_seq.size(), in_seq.size());
            for (int i = 0; i < in_seq.size() && i < out_seq.size(); i++)
                chk($sformatf("wrap.seq%0d", i), out_seq[i], in_seq[i]);
        end

        // Reset mid-operation with count=5, ovf=1 and vIn high.
        apply(1, 0, 0, 0, "rmo.rst");
        for (int i = 0; i < 9; i++) apply(0, 1, i + 16, 0, "rmo.fill");
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, "rmo.pop");
        chk("rmo.pre_count", int'(count), 5);
        chk("rmo.pre_ovf",   int'(ovf),   1);
        apply(1, 1, 'hAA, 1, "rmo.rst2");
        chk("rmo.count", int'(count), 0);
        chk("rmo.vOut",  int'(vOut),  0);
        chk("rmo.ovf",   int'(ovf),   0);
        chk("rmo.drop",  int'(drop_cnt), 0);
        apply(0, 0, 0, 0, "rmo.idle");
        chk("rmo.not_stored", int'(vOut), 0);

        // Long random run against the model, occasional resets.
        apply(1, 0, 0, 0, "rnd.rst");
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 4095)),
                  ($urandom_range(0, 1) == 1),
                  "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_out_fifo.md
IIR_OUT_FIFO -- requirements
Module: iir_out_fifo

Interface
REQ-001 Parameter: NB, default 12, sample width in bits; matches filter output width.
REQ-002 Parameter: DEPTH, default 8, number of storage entries; power of two, >= 2.
REQ-003 Parameter: CW, default 4, count width; equals clog2(DEPTH+1).
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: vIn  in  1  input sample valid, driven by the filter's vOut; no backpressure toward the filter.
REQ-007 Port: dIn  in  NB  input sample, driven by the filter's dOut; signed two's complement, passed through unmodified.
REQ-008 Port: ready  in  1  downstream consumer accepts the head sample this cycle.
REQ-009 Port: vOut  out  1  head sample valid; high whenever the FIFO is not empty.
REQ-010 Port: dOut  out  NB  head sample; defined only while vOut = 1.
REQ-011 Port: count  out  CW  current occupancy, 0..DEPTH.
REQ-012 Port: full  out  1  high when count = DEPTH.
REQ-013 Port: ovf  out  1  sticky flag; set when a sample is dropped.
REQ-014 Port: drop_cnt  out  16  number of dropped samples; see REQ-027.

Function
REQ-015 Push condition: vIn=1 and (full=0 or pop this cycle); dIn is written at the write pointer.
REQ-016 Pop condition: vOut=1 and ready=1; the read pointer advances.
REQ-017 Behaviour is first-word-fall-through: dOut always presents the entry at the read pointer, with no read latency.
REQ-018 Latency: a sample pushed into an empty FIFO raises vOut, with that sample on dOut, on the next clock edge.
REQ-019 Read and write pointers wrap from DEPTH-1 to 0.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 Simultaneous push and pop when full: the push is accepted, count stays DEPTH, and no drop occurs.
REQ-022 Simultaneous push and pop when empty: impossible because vOut=0, so only the push takes effect.
REQ-023 Drop: when vIn=1, full=1 and no pop occurs, the sample is discarded, ovf is set to 1, and stored contents are unchanged.
REQ-024 ready=1 while empty has no effect; pointers and count hold.
REQ-025 Output order equals input order; no sample is duplicated or reordered.

Reset
REQ-026 When rst=1 at a clock edge, regardless of vIn or ready:
  - read and write pointers, count and ovf are cleared to 0;
  - drop_cnt is cleared to 0;
  - vOut is 0 and full is 0 from the next cycle;
  - storage entries are not reset;
  - dOut is a don't-care while vOut=0;
  - reset mid-operation discards all contents;
  - a vIn pulse coincident with reset is not stored.

Configuration
REQ-027 Macro IIR_OUT_FIFO_DROP_CNT_EN:
  - when defined, drop_cnt increments by 1 on every drop (REQ-023) and saturates at 16'hFFFF;
  - when not defined, drop_cnt is tied to 0 and the counter logic is not synthesized;
  - ovf behaves identically in both builds.

Verification
REQ-028 Fill/drain: push 1,2,3 on consecutive cycles with ready=0, then hold ready=1. Required: count reaches 3; dOut yields 1,2,3 on consecutive cycles; vOut falls after 3; count ends at 0.
REQ-029 Latency: single push of 12'h7FF into an empty FIFO with ready=1. Required: vOut=1 and dOut=12'h7FF exactly one cycle later, popped that cycle, vOut=0 the cycle after.
REQ-030 Overflow: push 10 samples 0..9 with ready=0 (DEPTH=8). Required:
  - full=1 after 8 pushes;
  - ovf=1 after the 9th push;
  - drop_cnt=2 with the macro, 0 without;
  - drained data is 0..7.
REQ-031 Full push+pop: with FIFO full of 0..7, apply vIn=1, dIn=8 and ready=1 in the same cycle. Required: count stays 8, ovf stays 0, drained data is 1..8.
REQ-032 Wrap: 20 push/pop cycles with ready=1 at a random vIn duty. Required: output sequence equals input sequence and count never exceeds 1.
REQ-033 Reset mid-operation: with count=5 and ovf=1, assert rst for one cycle with vIn=1. Required: count=0, vOut=0, ovf=0, drop_cnt=0 next cycle, and the coincident sample is not stored.
